// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encodings and widths for the SRAM data-memory controller
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    SramIdle    = 3'd0,
    SramRd      = 3'd1,
    SramMerge   = 3'd2,
    SramWrSetup = 3'd3,
    SramWrPulse = 3'd4,
    SramWrHold  = 3'd5,
    SramDone    = 3'd6
  } sram_state_e;

  localparam int SramAddrBus = 20;
  localparam int SramWaitBus = 4;

  typedef logic [SramWaitBus-1:0] sram_wait_t;

endpackage

// File: rtl/sram_ctrl_byte_merge.sv
// rtl/sram_ctrl_byte_merge.sv - per-lane merge of a read word with new store data (used when SRAM_RMW_EN)
module sram_ctrl_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i +: 8] = sel_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
  end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - MEM-stage data memory over async SRAM; define SRAM_RMW_EN for read-modify-write partial stores
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = SramAddrBus,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam sram_wait_t WaitInit = sram_wait_t'(WAIT_CYCLES);

  sram_state_e       state_q, state_d;
  sram_wait_t        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       data_q;
  logic [31:0]       mem_data_q;
  logic [31:0]       merged_word;
  logic              rmw_req, rmw_q;
  logic              capture, rd_last, merge_en;
  logic [3:0]        wr_be_n;

  // Byte-aligned bits outside the SRAM word address are not decoded.
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef SRAM_RMW_EN
  logic [31:0] old_q;

  assign rmw_req = mem_we_i && (mem_sel_i != 4'hF) && (mem_sel_i != 4'h0);

  sram_ctrl_byte_merge u_merge (
    .old_i    (old_q),
    .new_i    (data_q),
    .sel_i    (sel_q),
    .merged_o (merged_word)
  );

  // Remember whether this store goes through the read phase, and the word read back for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_q <= 1'b0;
      old_q <= '0;
    end else begin
      if (capture) rmw_q <= rmw_req;
      if (rd_last && rmw_q) old_q <= sram_dq_i;
    end
  end
`else
  assign rmw_req     = 1'b0;
  assign rmw_q       = 1'b0;
  assign merged_word = data_q;
`endif

  // Partial stores under read-modify-write write the whole word.
  assign wr_be_n = rmw_q ? 4'h0 : ~sel_q;

  // State and cycle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SramIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and SRAM strobes decoded from the current state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    rd_last     = 1'b0;
    merge_en    = 1'b0;
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'hF;
    sram_dq_oe  = 1'b0;
    case (state_q)
      SramIdle: begin
        if (mem_ce_i) begin
          capture = 1'b1;
          cnt_d   = WaitInit;
          state_d = (!mem_we_i || rmw_req) ? SramRd : SramWrSetup;
        end
      end
      SramRd: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'h0;
        if (cnt_q == '0) begin
          rd_last = 1'b1;
          state_d = rmw_q ? SramMerge : SramDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SramMerge: begin
        merge_en = 1'b1;
        state_d  = SramWrSetup;
      end
      SramWrSetup: begin
        sram_ce_n_o = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_be_n_o = wr_be_n;
        cnt_d       = WaitInit;
        state_d     = SramWrPulse;
      end
      SramWrPulse: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_be_n_o = wr_be_n;
        if (cnt_q == '0) state_d = SramWrHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SramWrHold: begin
        sram_ce_n_o = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_be_n_o = wr_be_n;
        state_d     = SramDone;
      end
      SramDone: state_d = SramIdle;
      default:  state_d = SramIdle;
    endcase
  end

  // Request capture, read-data return and merged write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      mem_data_q <= '0;
    end else begin
      if (capture) begin
        addr_q <= mem_addr_i[ADDR_W+1:2];
        sel_q  <= mem_sel_i;
        data_q <= mem_data_i;
      end
      if (rd_last && !rmw_q) mem_data_q <= sram_dq_i;
      if (merge_en) data_q <= merged_word;
    end
  end

  // Stall is combinational so the pipeline holds in the request cycle itself.
  assign stall_req_o = (state_q == SramIdle) ? mem_ce_i : (state_q != SramDone);
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = data_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl with a behavioural SRAM
module tb_sram_ctrl;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_ce_i, mem_we_i;
  logic [31:0]       mem_addr_i, mem_data_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_o;
  logic              stall_req_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_dq_i, sram_dq_o;
  logic              sram_dq_oe, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]        sram_be_n_o;

  logic [31:0] mem [0:255];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .stall_req_o(stall_req_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
    end
  end

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, output int stall_n, output int pulses,
                           output int we_low, output logic [3:0] wr_be, output logic be_stable,
                           output logic conflict, output logic [ADDR_W-1:0] addr_seen,
                           output logic done_ok);
    logic prev_we, first_wr;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
    stall_n = 0; pulses = 0; we_low = 0; wr_be = 4'hF; be_stable = 1'b1;
    conflict = 1'b0; addr_seen = '0; done_ok = 1'b0; prev_we = 1'b1; first_wr = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (sram_dq_oe && !sram_oe_n_o) conflict = 1'b1;
      if (!sram_ce_n_o) addr_seen = sram_addr_o;
      if (sram_dq_oe) begin
        if (first_wr) begin wr_be = sram_be_n_o; first_wr = 1'b0; end
        else if (sram_be_n_o !== wr_be) be_stable = 1'b0;
      end
      if (!sram_we_n_o) begin
        we_low++;
        if (prev_we) pulses++;
      end
      prev_we = sram_we_n_o;
      if (!stall_req_o) begin done_ok = 1'b1; break; end
      stall_n++;
      @(negedge clk);
      mem_ce_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req_o); end
    checks++; if ({sram_ce_n_o, sram_oe_n_o, sram_we_n_o} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b expected 111", {sram_ce_n_o, sram_oe_n_o, sram_we_n_o}); end
    checks++; if (sram_be_n_o !== 4'hF || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_be_oe: got be=%b oe=%b expected 1111/0", sram_be_n_o, sram_dq_oe); end
    checks++; if (mem_data_o !== 32'h0 || sram_dq_o !== 32'h0 || sram_addr_o !== '0) begin errors++; $display("FAIL reset_regs: got data=%h dq=%h addr=%h expected zeros", mem_data_o, sram_dq_o, sram_addr_o); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (stall_req_o !== 1'b0 || sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got stall=%b ce_n=%b expected 0/1", stall_req_o, sram_ce_n_o); end
  endtask

  task automatic test_load;
    int s, p, wl; logic [3:0] be; logic bs, cf, ok; logic [ADDR_W-1:0] a;
    mem[4] = 32'hDEAD_BEEF;
    do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, s, p, wl, be, bs, cf, a, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL load_done: got %b expected 1 (timeout)", ok); end
    checks++; if (s != 3) begin errors++; $display("FAIL load_stall: got %0d expected 3", s); end
    checks++; if (a !== 20'd4) begin errors++; $display("FAIL load_addr: got %h expected 4", a); end
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", mem_data_o); end
    checks++; if (wl != 0 || cf !== 1'b0) begin errors++; $display("FAIL load_strobes: got we_low=%0d conflict=%b expected 0/0", wl, cf); end
  endtask

  task automatic test_store_full;
    int s, p, wl; logic [3:0] be; logic bs, cf, ok; logic [ADDR_W-1:0] a;
    mem[8] = 32'h0;
    do_access(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, s, p, wl, be, bs, cf, a, ok);
    checks++; if (s != 5 || ok !== 1'b1) begin errors++; $display("FAIL store_stall: got %0d ok=%b expected 5", s, ok); end
    checks++; if (p != 1 || wl != 2) begin errors++; $display("FAIL store_pulse: got pulses=%0d low=%0d expected 1/2", p, wl); end
    checks++; if (be !== 4'h0 || bs !== 1'b1) begin errors++; $display("FAIL store_be: got %b stable=%b expected 0000", be, bs); end
    checks++; if (mem[8] !== 32'h1234_5678) begin errors++; $display("FAIL store_mem: got %h expected 12345678", mem[8]); end
    checks++; if (mem_data_o !== 32'hDEAD_BEEF || cf !== 1'b0) begin errors++; $display("FAIL store_keeps_rdata: got %h cf=%b expected deadbeef", mem_data_o, cf); end
  endtask

  task automatic test_store_partial;
    int s, p, wl; logic [3:0] be; logic bs, cf, ok; logic [ADDR_W-1:0] a;
    int exp_s; logic [3:0] exp_be;
`ifdef SRAM_RMW_EN
    exp_s = 8; exp_be = 4'b0000;
`else
    exp_s = 5; exp_be = 4'b1011;
`endif
    mem[3] = 32'h1122_3344;
    do_access(1'b1, 32'h0000_000C, 4'b0100, 32'hABAB_ABAB, s, p, wl, be, bs, cf, a, ok);
    checks++; if (s != exp_s || ok !== 1'b1) begin errors++; $display("FAIL sb_stall: got %0d expected %0d", s, exp_s); end
    checks++; if (be !== exp_be || bs !== 1'b1) begin errors++; $display("FAIL sb_be: got %b stable=%b expected %b", be, bs, exp_be); end
    checks++; if (mem[3] !== 32'h11AB_3344) begin errors++; $display("FAIL sb_mem: got %h expected 11ab3344", mem[3]); end
    checks++; if (mem_data_o !== 32'hDEAD_BEEF || p != 1 || cf !== 1'b0) begin errors++; $display("FAIL sb_side: got rdata=%h pulses=%0d cf=%b expected deadbeef/1/0", mem_data_o, p, cf); end
  endtask

  task automatic test_capture_hold;
    mem[16] = 32'hCAFE_0001; mem[32] = 32'hCAFE_0002;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40; mem_sel_i = 4'hF;
    #1;
    checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL cap_req_stall: got %b expected 1", stall_req_o); end
    @(negedge clk); mem_addr_i = 32'h80;
    #1;
    checks++; if (sram_addr_o !== 20'h10) begin errors++; $display("FAIL cap_addr_held: got %h expected 10", sram_addr_o); end
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (stall_req_o !== 1'b0 || mem_data_o !== 32'hCAFE_0001) begin errors++; $display("FAIL cap_done: got stall=%b data=%h expected 0/cafe0001", stall_req_o, mem_data_o); end
    @(negedge clk); #1;
    checks++; if (stall_req_o !== 1'b1 || sram_addr_o !== 20'h10) begin errors++; $display("FAIL cap_next_idle: got stall=%b addr=%h expected 1/10", stall_req_o, sram_addr_o); end
    @(negedge clk); mem_ce_i = 1'b0; #1;
    checks++; if (sram_addr_o !== 20'h20) begin errors++; $display("FAIL cap_second_addr: got %h expected 20", sram_addr_o); end
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (stall_req_o !== 1'b0 || mem_data_o !== 32'hCAFE_0002) begin errors++; $display("FAIL cap_second_data: got stall=%b data=%h expected 0/cafe0002", stall_req_o, mem_data_o); end
  endtask

  task automatic test_store_sel0;
    int s, p, wl; logic [3:0] be; logic bs, cf, ok; logic [ADDR_W-1:0] a;
    mem[5] = 32'h55AA_55AA;
    do_access(1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, s, p, wl, be, bs, cf, a, ok);
    checks++; if (s != 5 || p != 1 || ok !== 1'b1) begin errors++; $display("FAIL sel0_timing: got stall=%0d pulses=%0d expected 5/1", s, p); end
    checks++; if (be !== 4'hF) begin errors++; $display("FAIL sel0_be: got %b expected 1111", be); end
    checks++; if (mem[5] !== 32'h55AA_55AA || mem_data_o !== 32'hCAFE_0002) begin errors++; $display("FAIL sel0_unchanged: got mem=%h rdata=%h expected 55aa55aa/cafe0002", mem[5], mem_data_o); end
  endtask

  task automatic test_reset_mid_write;
    int s, p, wl; logic [3:0] be; logic bs, cf, ok; logic [ADDR_W-1:0] a;
    mem[6] = 32'h600D_600D;
    @(negedge clk);
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h18; mem_sel_i = 4'hF; mem_data_i = 32'hBAD0_BAD0;
    @(negedge clk); mem_ce_i = 1'b0;
    @(negedge clk); #1;
    checks++; if (sram_we_n_o !== 1'b0) begin errors++; $display("FAIL rstw_in_pulse: got we_n=%b expected 0", sram_we_n_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({sram_we_n_o, sram_ce_n_o, sram_dq_oe, stall_req_o} !== 4'b1100) begin errors++; $display("FAIL rstw_immediate: got we_n,ce_n,oe,stall=%b expected 1100", {sram_we_n_o, sram_ce_n_o, sram_dq_oe, stall_req_o}); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (mem[6] !== 32'h600D_600D || mem_data_o !== 32'h0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL rstw_after: got mem=%h rdata=%h stall=%b expected 600d600d/0/0", mem[6], mem_data_o, stall_req_o); end
    do_access(1'b0, 32'h0000_0018, 4'hF, 32'h0, s, p, wl, be, bs, cf, a, ok);
    checks++; if (s != 3 || mem_data_o !== 32'h600D_600D) begin errors++; $display("FAIL rstw_reload: got stall=%0d data=%h expected 3/600d600d", s, mem_data_o); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_load;
    test_store_full;
    test_store_partial;
    test_capture_hold;
    test_store_sel0;
    test_reset_mid_write;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
